// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. One operation is in
// flight at a time. The flow is IDLE (grant and latch) -> EXEC (capture the
// ALU result) -> RESP (hold the result until the owner consumes it).
//
// Parameters
//   RR_EN        1: round-robin between requesters on a tie
//                0: fixed priority, requester 0 wins a tie
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   reqN_valid / reqN_ready    request handshake for requester N (0,1)
//   reqN_a, reqN_b, reqN_op    operands and opcode for requester N
//   rspN_valid / rspN_ready    response handshake for requester N
//   rsp_result, rsp_flag       shared response payload
//   alu_a, alu_b, alu_op       operands driven to the shared ALU
//   alu_result, alu_flag       combinational ALU outputs
// ---------------------------------------------------------------------------
module alu_arbiter #(
   parameter int RR_EN = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [4:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [4:0]  req1_op,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_flag,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_op,
   input  logic [31:0] alu_result,
   input  logic        alu_flag
);

   localparam bit RR = (RR_EN != 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_reg;
   state_t      state_next;
   logic        prio_reg;     // requester that wins the next tie
   logic        id_reg;       // requester owning the in-flight operation
   logic [31:0] a_reg;
   logic [31:0] b_reg;
   logic [4:0]  op_reg;
   logic [31:0] result_reg;
   logic        flag_reg;

   logic        any_valid;
   logic        grant_id;
   logic        accept;
   logic        rsp_sel_ready;

   assign any_valid = req0_valid | req1_valid;

   // A lone requester always wins; the pointer only matters on a tie.
   always_comb begin
      grant_id = req1_valid;
      if (req0_valid && req1_valid) begin
         grant_id = RR ? prio_reg : 1'b0;
      end
   end

   assign accept        = (state_reg == IDLE) && any_valid;
   // Only the owner's ready can complete the response; the other is ignored.
   assign rsp_sel_ready = id_reg ? rsp1_ready : rsp0_ready;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (any_valid) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (rsp_sel_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   // Handshake outputs are masked by rst_n so nothing is offered or
   // delivered during the reset cycle, whatever state the register holds.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      if (rst_n) begin
         req0_ready = accept && !grant_id;
         req1_ready = accept &&  grant_id;
         rsp0_valid = (state_reg == RESP) && !id_reg;
         rsp1_valid = (state_reg == RESP) &&  id_reg;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio_reg   <= 1'b0;
         id_reg     <= 1'b0;
         a_reg      <= '0;
         b_reg      <= '0;
         op_reg     <= '0;
         result_reg <= '0;
         flag_reg   <= 1'b0;
      end else begin
         if (accept) begin
            id_reg <= grant_id;
            a_reg  <= grant_id ? req1_a  : req0_a;
            b_reg  <= grant_id ? req1_b  : req0_b;
            op_reg <= grant_id ? req1_op : req0_op;
         end
         if (state_reg == EXEC) begin
            result_reg <= alu_result;
            flag_reg   <= alu_flag;
         end
         // Hand the next tie to the requester that was not just served.
         if ((state_reg == RESP) && rsp_sel_ready) begin
            prio_reg <= ~id_reg;
         end
      end
   end

   // The ALU only ever sees registered operands.
   assign alu_a      = a_reg;
   assign alu_b      = b_reg;
   assign alu_op     = op_reg;
   assign rsp_result = result_reg;
   assign rsp_flag   = flag_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Drives two arbiter instances (round-robin and fixed priority) with the same
// directed request stream. Each instance gets its own behavioural ALU.
// ALU codes used here: 0 ADD, 1 SUB, 2 BEQ (result a-b), others -> ~a.
// The flag is (a == b) for every code.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

   localparam logic [4:0] OP_ADD = 5'd0;
   localparam logic [4:0] OP_SUB = 5'd1;
   localparam logic [4:0] OP_BEQ = 5'd2;
   localparam logic [4:0] OP_UNK = 5'd31;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [4:0]  req0_op, req1_op;
   logic        rsp0_ready, rsp1_ready;

   // round-robin instance
   logic        rr_req0_ready, rr_req1_ready, rr_rsp0_valid, rr_rsp1_valid;
   logic [31:0] rr_rsp_result, rr_alu_a, rr_alu_b, rr_alu_result;
   logic        rr_rsp_flag, rr_alu_flag;
   logic [4:0]  rr_alu_op;

   // fixed-priority instance
   logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
   logic [31:0] fp_rsp_result, fp_alu_a, fp_alu_b, fp_alu_result;
   logic        fp_rsp_flag, fp_alu_flag;
   logic [4:0]  fp_alu_op;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [32:0] alu_model(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [4:0]  op);
      logic [31:0] r;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_BEQ:  r = a - b;
         default: r = ~a;
      endcase
      return {(a == b), r};
   endfunction

   assign {rr_alu_flag, rr_alu_result} = alu_model(rr_alu_a, rr_alu_b, rr_alu_op);
   assign {fp_alu_flag, fp_alu_result} = alu_model(fp_alu_a, fp_alu_b, fp_alu_op);

   alu_arbiter #(.RR_EN(1)) dut_rr (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(rr_req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(rr_req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp0_valid(rr_rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rr_rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rr_rsp_result), .rsp_flag(rr_rsp_flag),
      .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_op(rr_alu_op),
      .alu_result(rr_alu_result), .alu_flag(rr_alu_flag)
   );

   alu_arbiter #(.RR_EN(0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(fp_req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(fp_req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(fp_rsp_result), .rsp_flag(fp_rsp_flag),
      .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_op(fp_alu_op),
      .alu_result(fp_alu_result), .alu_flag(fp_alu_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_r0;
   logic [31:0] exp_r1;

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req0_op = OP_ADD;
      req1_a = '0; req1_b = '0; req1_op = OP_ADD;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;

      // ---------------- reset state ----------------
      step(); step();
      #1;
      check("rst_req0_ready", {31'b0, rr_req0_ready}, 32'd0);
      check("rst_rsp0_valid", {31'b0, rr_rsp0_valid}, 32'd0);
      check("rst_rsp1_valid", {31'b0, rr_rsp1_valid}, 32'd0);
      check("rst_rsp_result", rr_rsp_result, 32'd0);
      check("rst_alu_a", rr_alu_a, 32'd0);
      check("rst_alu_op", {27'b0, rr_alu_op}, 32'd0);
      $display("txn: reset checked");

      // ---------------- single request, granted in first cycle out of reset
      rst_n = 1'b1;
      req0_a = 32'd5; req0_b = 32'd7; req0_op = OP_ADD; rsp0_ready = 1'b1;
      #1;
      check("single_req0_ready", {31'b0, rr_req0_ready}, 32'd1);
      check("single_req1_ready", {31'b0, rr_req1_ready}, 32'd0);
      step();
      req0_valid = 1'b0;
      #1;
      check("single_exec_alu_a", rr_alu_a, 32'd5);
      check("single_exec_alu_b", rr_alu_b, 32'd7);
      check("single_exec_rsp0_valid", {31'b0, rr_rsp0_valid}, 32'd0);
      step(); #1;
      check("single_rsp0_valid", {31'b0, rr_rsp0_valid}, 32'd1);
      check("single_rsp1_valid", {31'b0, rr_rsp1_valid}, 32'd0);
      check("single_result", rr_rsp_result, 32'd12);
      check("single_flag", {31'b0, rr_rsp_flag}, 32'd0);
      $display("txn: req0 ADD 5+7 -> %0d", rr_rsp_result);
      step(); #1;
      check("single_rsp0_drop", {31'b0, rr_rsp0_valid}, 32'd0);

      // ---------------- contention: fresh pointer, both valid ----------------
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_a = 32'd10;  req0_b = 32'd3; req0_op = OP_ADD;
      req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd1; req1_op = OP_SUB;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("rr_grant0", {31'b0, rr_req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
         check("rr_grant1", {31'b0, rr_req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
         check("fp_grant0", {31'b0, fp_req0_ready}, 32'd1);
         check("fp_grant1", {31'b0, fp_req1_ready}, 32'd0);
         step();
         step(); #1;
         check("rr_rsp0_valid", {31'b0, rr_rsp0_valid}, (k % 2 == 0) ? 32'd1 : 32'd0);
         check("rr_rsp1_valid", {31'b0, rr_rsp1_valid}, (k % 2 == 1) ? 32'd1 : 32'd0);
         check("rr_result", rr_rsp_result, (k % 2 == 0) ? 32'd13 : 32'd99);
         check("fp_rsp0_valid", {31'b0, fp_rsp0_valid}, 32'd1);
         check("fp_rsp1_valid", {31'b0, fp_rsp1_valid}, 32'd0);
         check("fp_result", fp_rsp_result, 32'd13);
         check("fp_flag", {31'b0, fp_rsp_flag}, 32'd0);
         $display("txn: contention %0d rr_result=%0d fp_result=%0d", k,
                  rr_rsp_result, fp_rsp_result);
         step();
         if (k == 3) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
      end

      // ---------------- backpressure on req1 BEQ 9,9 ----------------
      req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_op = OP_BEQ;
      rsp1_ready = 1'b0; rsp0_ready = 1'b1;
      #1;
      check("bp_req1_ready", {31'b0, rr_req1_ready}, 32'd1);
      check("bp_req0_ready", {31'b0, rr_req0_ready}, 32'd0);
      step();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_a = 32'h0F0F_0F0F; req0_b = 32'd0; req0_op = OP_UNK;
      #1;
      check("bp_exec_req0_ready", {31'b0, rr_req0_ready}, 32'd0);
      step();
      for (int c = 0; c < 10; c++) begin
         #1;
         check("bp_rsp1_valid", {31'b0, rr_rsp1_valid}, 32'd1);
         check("bp_rsp0_valid", {31'b0, rr_rsp0_valid}, 32'd0);
         check("bp_flag", {31'b0, rr_rsp_flag}, 32'd1);
         check("bp_result", rr_rsp_result, 32'd0);
         check("bp_no_grant", {31'b0, rr_req0_ready}, 32'd0);
         step();
      end
      rsp1_ready = 1'b1;
      #1;
      check("bp_release_rsp1_valid", {31'b0, rr_rsp1_valid}, 32'd1);
      $display("txn: req1 BEQ 9,9 flag=%0d after backpressure", rr_rsp_flag);
      step();
      rsp1_ready = 1'b0;
      #1;
      check("bp_rsp1_drop", {31'b0, rr_rsp1_valid}, 32'd0);
      check("pending_req0_ready", {31'b0, rr_req0_ready}, 32'd1);
      step();
      req0_valid = 1'b0;
      #1;
      check("unk_alu_op", {27'b0, rr_alu_op}, 32'd31);
      check("unk_alu_a", rr_alu_a, 32'h0F0F_0F0F);
      step(); #1;
      check("unk_rsp0_valid", {31'b0, rr_rsp0_valid}, 32'd1);
      check("unk_result", rr_rsp_result, 32'hF0F0_F0F0);
      $display("txn: req0 op31 -> %h", rr_rsp_result);
      step();

      // ---------------- reset during EXEC (pointer currently 1) ----------------
      req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd4; req0_op = OP_ADD;
      #1;
      check("rmid_req0_ready", {31'b0, rr_req0_ready}, 32'd1);
      step();
      req0_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rmid_rsp0_valid", {31'b0, rr_rsp0_valid}, 32'd0);
      step(); #1;
      check("rmid_alu_a", rr_alu_a, 32'd0);
      check("rmid_alu_op", {27'b0, rr_alu_op}, 32'd0);
      check("rmid_rsp_result", rr_rsp_result, 32'd0);
      check("rmid_rsp_flag", {31'b0, rr_rsp_flag}, 32'd0);
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_a = 32'd2;  req0_b = 32'd3; req0_op = OP_ADD;
      req1_valid = 1'b1; req1_a = 32'd50; req1_b = 32'd8; req1_op = OP_SUB;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      exp_r0 = 32'd5;
      exp_r1 = 32'd42;
      #1;
      check("rmid_idle_rsp0_valid", {31'b0, rr_rsp0_valid}, 32'd0);
      check("rmid_tie_req0_ready", {31'b0, rr_req0_ready}, 32'd1);
      check("rmid_tie_req1_ready", {31'b0, rr_req1_ready}, 32'd0);
      step();
      req0_valid = 1'b0;
      #1;
      check("rmid_exec_rsp0_valid", {31'b0, rr_rsp0_valid}, 32'd0);
      step(); #1;
      check("rmid_rsp0_valid", {31'b0, rr_rsp0_valid}, 32'd1);
      check("rmid_result0", rr_rsp_result, exp_r0);
      $display("txn: after reset req0 ADD 2+3 -> %0d", rr_rsp_result);
      step(); #1;
      check("rmid_req1_ready", {31'b0, rr_req1_ready}, 32'd1);
      step();
      req1_valid = 1'b0;
      step(); #1;
      check("rmid_rsp1_valid", {31'b0, rr_rsp1_valid}, 32'd1);
      check("rmid_result1", rr_rsp_result, exp_r1);
      $display("txn: after reset req1 SUB 50-8 -> %0d", rr_rsp_result);
      step(); #1;
      check("rmid_rsp1_drop", {31'b0, rr_rsp1_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #100000;
      $display("FAIL timeout: got no finish, expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
